// File: rtl/pll_lock_sequencer.sv
// rPLL bring-up/runtime controller: reset pulse, lock qualify, retry, PSDA/DUTYDA apply. Auto-relock under PLL_LOCK_SEQUENCER_RELOCK_EN.
// Latency: lock decisions lag pll_lock by 2 sync cycles; every output is registered from the next state.
// Backpressure: cfg_ready is high only in RUN; a request waits (not dropped) until the settle window ends.
module pll_lock_sequencer #(
  parameter int         RESET_PULSE_CYCLES  = 16,
  parameter int         LOCK_STABLE_CYCLES  = 1024,
  parameter int         LOCK_TIMEOUT_CYCLES = 65535,
  parameter int         MAX_RETRIES         = 3,
  parameter int         SETTLE_CYCLES       = 16,
  parameter logic [3:0] PSDA_INIT           = 4'b0000,
  parameter logic [3:0] DUTYDA_INIT         = 4'b1000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_pll_lock,
  output logic       o_pll_reset,
  output logic [3:0] o_psda,
  output logic [3:0] o_dutyda,
  input  logic       i_cfg_valid,
  input  logic [3:0] i_cfg_psda,
  input  logic [3:0] i_cfg_dutyda,
  output logic       o_cfg_ready,
  output logic       o_sys_rst,
  output logic       o_locked,
  output logic       o_fail,
  output logic [3:0] o_retry_cnt,
  output logic [7:0] o_relock_cnt
);

  localparam int CMAX_A = (RESET_PULSE_CYCLES > SETTLE_CYCLES) ? RESET_PULSE_CYCLES : SETTLE_CYCLES;
  localparam int CMAX   = (CMAX_A > LOCK_TIMEOUT_CYCLES) ? CMAX_A : LOCK_TIMEOUT_CYCLES;
  localparam int CW     = $clog2(CMAX + 1);
  localparam int SW     = $clog2(LOCK_STABLE_CYCLES + 1);

  localparam logic [CW-1:0] C_RST_LAST    = CW'(RESET_PULSE_CYCLES - 1);
  localparam logic [CW-1:0] C_TMO_LAST    = CW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] C_SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [SW-1:0] C_STB_LAST    = SW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [3:0]    C_MAXR        = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_RESET_PULSE,
    S_WAIT_LOCK,
    S_RUN,
    S_APPLY,
    S_RELOCK,
    S_FAIL
  } state_t;

`ifdef PLL_LOCK_SEQUENCER_RELOCK_EN
  localparam state_t S_LOSS = S_RELOCK;
`else
  localparam state_t S_LOSS = S_FAIL;
`endif

  state_t        r_state;
  state_t        w_next;
  logic [1:0]    r_sync;
  logic          w_lock_s;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic [SW-1:0] r_stb;
  logic [SW-1:0] w_stb_nxt;
  logic          w_stb_done;
  logic [3:0]    r_retry;
  logic [3:0]    w_retry_nxt;
  logic          w_cfg_take;
  logic          w_run_nxt;
  logic          r_pll_reset;
  logic          r_sys_rst;
  logic          r_locked;
  logic          r_fail;
  logic          r_cfg_ready;
  logic [3:0]    r_psda;
  logic [3:0]    r_dutyda;

  assign w_lock_s   = r_sync[1];
  assign w_stb_done = w_lock_s && (r_stb == C_STB_LAST);

  always_comb begin
    w_next      = r_state;
    w_cnt_nxt   = '0;
    w_stb_nxt   = '0;
    w_retry_nxt = r_retry;
    w_cfg_take  = 1'b0;
    case (r_state)
      S_RESET_PULSE: begin
        if (r_cnt == C_RST_LAST) w_next = S_WAIT_LOCK;
        else                     w_cnt_nxt = r_cnt + 1'b1;
      end
      S_WAIT_LOCK: begin
        // A stable-lock completion beats a timeout landing on the same cycle.
        if (w_stb_done) begin
          w_next = S_RUN;
        end else if (r_cnt == C_TMO_LAST) begin
          if (r_retry == C_MAXR) begin
            w_next = S_FAIL;
          end else begin
            w_retry_nxt = r_retry + 1'b1;
            w_next      = S_RESET_PULSE;
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
          if (w_lock_s) w_stb_nxt = r_stb + 1'b1;
        end
      end
      S_RUN: begin
        if (!w_lock_s) begin
          w_next = S_LOSS;
        end else if (i_cfg_valid && r_cfg_ready) begin
          w_cfg_take = 1'b1;
          w_next     = S_APPLY;
        end
      end
      S_APPLY: begin
        if (!w_lock_s)                   w_next = S_LOSS;
        else if (r_cnt == C_SETTLE_LAST) w_next = S_RUN;
        else                             w_cnt_nxt = r_cnt + 1'b1;
      end
`ifdef PLL_LOCK_SEQUENCER_RELOCK_EN
      S_RELOCK: begin
        w_retry_nxt = '0;
        w_next      = S_RESET_PULSE;
      end
`endif
      S_FAIL:  w_next = S_FAIL;
      default: w_next = S_FAIL;
    endcase
  end

  assign w_run_nxt = (w_next == S_RUN) || (w_next == S_APPLY);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync      <= '0;
      r_state     <= S_RESET_PULSE;
      r_cnt       <= '0;
      r_stb       <= '0;
      r_retry     <= '0;
      r_pll_reset <= 1'b1;
      r_sys_rst   <= 1'b1;
      r_locked    <= 1'b0;
      r_fail      <= 1'b0;
      r_cfg_ready <= 1'b0;
      r_psda      <= PSDA_INIT;
      r_dutyda    <= DUTYDA_INIT;
    end else begin
      r_sync      <= {r_sync[0], i_pll_lock};
      r_state     <= w_next;
      r_cnt       <= w_cnt_nxt;
      r_stb       <= w_stb_nxt;
      r_retry     <= w_retry_nxt;
      r_pll_reset <= (w_next == S_RESET_PULSE) || (w_next == S_FAIL);
      r_sys_rst   <= !w_run_nxt;
      r_locked    <= w_run_nxt;
      r_fail      <= (w_next == S_FAIL);
      r_cfg_ready <= (w_next == S_RUN);
      if (w_cfg_take) begin
        r_psda   <= i_cfg_psda;
        r_dutyda <= i_cfg_dutyda;
      end
    end
  end

`ifdef PLL_LOCK_SEQUENCER_RELOCK_EN
  logic [7:0] r_relock;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_relock <= '0;
    end else if ((r_state == S_RUN || r_state == S_APPLY) && w_next == S_RELOCK
                 && r_relock != 8'hFF) begin
      r_relock <= r_relock + 1'b1;
    end
  end

  assign o_relock_cnt = r_relock;
`else
  assign o_relock_cnt = 8'd0;
`endif

  assign o_pll_reset = r_pll_reset;
  assign o_sys_rst   = r_sys_rst;
  assign o_locked    = r_locked;
  assign o_fail      = r_fail;
  assign o_cfg_ready = r_cfg_ready;
  assign o_psda      = r_psda;
  assign o_dutyda    = r_dutyda;
  assign o_retry_cnt = r_retry;

endmodule
